// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sample pairing FIFO.
package fib_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 2 * BYTE_W;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pair_state_e;

    // Word layout: the later sample sits in the upper byte.
    typedef struct packed {
        byte_t second;
        byte_t first;
    } pair_t;

    localparam byte_t DROP_MAX = 8'hFF;

    function automatic word_t pack_pair(byte_t first, byte_t second);
        pair_t p;
        p.first  = first;
        p.second = second;
        return word_t'(p);
    endfunction

endpackage

// File: rtl/fib_pair_fifo_if.sv
// Sample-in / word-out handshake bundle for fib_pair_fifo.
interface fib_pair_fifo_if;
    import fib_pkg::*;

    logic  in_valid;
    byte_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/fib_fifo.sv
// DEPTH-entry word FIFO with extra-MSB pointers; head reads as zero when empty.
module fib_fifo
    import fib_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  word_t wdata_i,
    input  logic  pop_i,
    output logic  push_ok_c,
    output logic  full_c,
    output logic  empty_c,
    output word_t head_c
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    word_t            mem_q [DEPTH];
    logic             do_pop_c;
    logic             do_push_c;

    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign full_c    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                       (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign do_pop_c  = pop_i && !empty_c;
    // A pop frees the slot in the same edge, so a full FIFO still takes the push.
    assign push_ok_c = !full_c || do_pop_c;
    assign do_push_c = push_i && push_ok_c;
    assign head_c    = empty_c ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata_i;
                wr_ptr_q                   <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fib_pair_fifo.sv
// Packs 8-bit generator samples into 16-bit words, buffers them and counts drops.
// Optional recurrence checker enabled by defining FIB_CHECK_EN (adds chk_err port).
module fib_pair_fifo
    import fib_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fib_pair_fifo_if.slave        bus,
    output logic                  overflow,
    output byte_t                 drop_cnt
`ifdef FIB_CHECK_EN
    ,
    output logic                  chk_err
`endif
);

    pair_state_e state_q, state_d;
    byte_t       held_q, held_d;
    logic        push_c;
    word_t       word_c;
    logic        pop_c;
    logic        push_ok_c;
    logic        full_c;
    logic        empty_c;
    word_t       head_c;
    logic        drop_c;
    logic        overflow_q;
    byte_t       drop_cnt_q;

    // Pairing FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    // Pairing FSM: next state and push request.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        push_c  = 1'b0;
        word_c  = pack_pair(held_q, bus.in_data);
        if (bus.in_valid) begin
            case (state_q)
                EMPTY: begin
                    held_d  = bus.in_data;
                    state_d = HALF;
                end
                HALF: begin
                    push_c  = 1'b1;
                    state_d = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign pop_c = !empty_c && bus.out_ready;

    fib_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push_i    (push_c),
        .wdata_i   (word_c),
        .pop_i     (pop_c),
        .push_ok_c (push_ok_c),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .head_c    (head_c)
    );

    assign bus.out_valid = !empty_c;
    assign bus.out_data  = head_c;

    // Drop accounting: sticky flag plus saturating counter.
    assign drop_c = push_c && !push_ok_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop_c) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

`ifdef FIB_CHECK_EN
    byte_t       h1_q;
    byte_t       h2_q;
    logic [1:0]  cnt_q;
    logic        chk_err_q;
    byte_t       sum_c;

    assign sum_c = h1_q + h2_q;

    // Recurrence check sees every sample, whether or not its word is later dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h1_q      <= '0;
            h2_q      <= '0;
            cnt_q     <= '0;
            chk_err_q <= 1'b0;
        end else if (bus.in_valid) begin
            if ((cnt_q == 2'd2) && (bus.in_data != sum_c)) begin
                chk_err_q <= 1'b1;
            end
            h2_q <= h1_q;
            h1_q <= bus.in_data;
            if (cnt_q != 2'd2) begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule
